// File: rtl/main_memory_responder.sv
// rtl/main_memory_responder.sv - fixed-latency word-wide backing store for the cache memory port
module main_memory_responder #(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 4
) (
    input  logic            clk,
    input  logic            rst_b,
    input  logic            mem_req,
    input  logic            mem_write_en,
    input  logic [31:0]     mem_addr,
    input  logic [0:3][7:0] mem_data_in,
    output logic [0:3][7:0] mem_data_out,
    output logic            mem_busy,
    output logic            mem_ready,
    output logic            mem_err
);

    localparam int         DEPTH    = 1 << ADDR_W;
    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BUSY  = 1'b1;
    localparam logic [7:0] CNT_LOAD = 8'(LATENCY - 1);

    logic [0:0]        state;
    logic [7:0]        cnt;
    logic              we_q;
    logic [31:0]       addr_q;
    logic [31:0]       data_q;
    logic [31:0]       storage [DEPTH];

    logic [ADDR_W-1:0] idx;
    logic              out_of_range;
    logic              done;
    logic              unused_addr_lsbs;

    assign idx              = addr_q[ADDR_W+1:2];
    assign out_of_range     = (addr_q >> (ADDR_W + 2)) != 32'd0;
    assign done             = (state == ST_BUSY) && (cnt == 8'd0);
    assign unused_addr_lsbs = ^addr_q[1:0];
    assign mem_busy         = (state == ST_BUSY);

    always_ff @(posedge clk) begin
        if (rst_b) begin
            state        <= ST_IDLE;
            cnt          <= 8'd0;
            mem_ready    <= 1'b0;
            mem_err      <= 1'b0;
            mem_data_out <= '0;
        end else begin
            mem_ready <= 1'b0;
            mem_err   <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (mem_req) begin
                        addr_q <= mem_addr;
                        we_q   <= mem_write_en;
                        data_q <= mem_data_in;
                        cnt    <= CNT_LOAD;
                        state  <= ST_BUSY;
                    end
                end
                ST_BUSY: begin
                    if (cnt != 8'd0) begin
                        cnt <= cnt - 8'd1;
                    end else begin
                        state     <= ST_IDLE;
                        mem_ready <= 1'b1;
                        mem_err   <= out_of_range;
                        // Reads update the output register; writes leave the last read data visible.
                        if (!we_q) begin
                            mem_data_out <= out_of_range ? '0 : storage[idx];
                        end
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Storage is never reset; reset only has to keep an aborted write from landing.
    always_ff @(posedge clk) begin
        if (!rst_b && done && we_q && !out_of_range) begin
            storage[idx] <= data_q;
        end
    end

endmodule

// File: tb/tb_main_memory_responder.sv
// tb/tb_main_memory_responder.sv - table, directed and randomized checks for main_memory_responder
module tb_main_memory_responder;

    localparam int LAT    = 4;
    localparam int ADDR_W = 10;

    logic            clk = 1'b0;
    logic            rst_b = 1'b1;
    logic            mem_req = 1'b0;
    logic            mem_write_en = 1'b0;
    logic [31:0]     mem_addr = 32'd0;
    logic [0:3][7:0] mem_data_in = '0;
    logic [0:3][7:0] mem_data_out;
    logic            mem_busy, mem_ready, mem_err;

    logic            l1_req = 1'b0;
    logic            l1_write_en = 1'b0;
    logic [31:0]     l1_addr = 32'd0;
    logic [0:3][7:0] l1_data_in = '0;
    logic [0:3][7:0] l1_data_out;
    logic            l1_busy, l1_ready, l1_err;

    int checks = 0;
    int failures = 0;

    logic [31:0] model_mem [32];
    logic [31:0] model_dout;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] data;
        logic        exp_err;
        logic [31:0] exp_dout;
    } vec_t;

    vec_t vecs [12];

    main_memory_responder #(.ADDR_W(ADDR_W), .LATENCY(LAT)) dut (
        .clk(clk), .rst_b(rst_b), .mem_req(mem_req), .mem_write_en(mem_write_en),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_data_out(mem_data_out),
        .mem_busy(mem_busy), .mem_ready(mem_ready), .mem_err(mem_err)
    );

    main_memory_responder #(.ADDR_W(ADDR_W), .LATENCY(1)) dut_l1 (
        .clk(clk), .rst_b(rst_b), .mem_req(l1_req), .mem_write_en(l1_write_en),
        .mem_addr(l1_addr), .mem_data_in(l1_data_in), .mem_data_out(l1_data_out),
        .mem_busy(l1_busy), .mem_ready(l1_ready), .mem_err(l1_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        mem_req = 1'b0;
        l1_req  = 1'b0;
        rst_b   = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset busy", 32'(mem_busy), 32'd0);
        chk("reset ready", 32'(mem_ready), 32'd0);
        chk("reset err", 32'(mem_err), 32'd0);
        chk("reset dout", mem_data_out, 32'd0);
        rst_b = 1'b0;
        model_dout = 32'd0;
    endtask

    // Issues one request in the current cycle and follows it until its ready cycle.
    task automatic run_req(input logic we, input logic [31:0] addr, input logic [31:0] data,
                           input logic exp_err, input logic [31:0] exp_dout,
                           input bit noise, input logic [31:0] n_addr, input logic [31:0] n_data,
                           input string tag);
        mem_req      = 1'b1;
        mem_write_en = we;
        mem_addr     = addr;
        mem_data_in  = data;
        for (int j = 0; j <= LAT; j++) begin
            @(posedge clk);
            #1;
            if (j < LAT) begin
                chk({tag, " busy"}, 32'(mem_busy), 32'd1);
                chk({tag, " early ready"}, 32'(mem_ready), 32'd0);
                mem_req      = noise;
                mem_write_en = noise ? 1'b1 : 1'($urandom_range(0, 1));
                mem_addr     = noise ? n_addr : $urandom;
                mem_data_in  = noise ? n_data : $urandom;
            end else begin
                chk({tag, " done busy"}, 32'(mem_busy), 32'd0);
                chk({tag, " ready"}, 32'(mem_ready), 32'd1);
                chk({tag, " err"}, 32'(mem_err), 32'(exp_err));
                chk({tag, " dout"}, mem_data_out, exp_dout);
                mem_req = 1'b0;
            end
        end
    endtask

    initial begin
        logic [31:0] addr, data, exp_dout;
        logic        we, oor;
        int          idx;

        vecs[0]  = '{1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 1'b0, 32'h0000_0000};
        vecs[1]  = '{1'b0, 32'h0000_0013, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[2]  = '{1'b1, 32'h0000_0024, 32'hCAFE_F00D, 1'b0, 32'hDEAD_BEEF};
        vecs[3]  = '{1'b1, 32'h0000_0000, 32'h0123_4567, 1'b0, 32'hDEAD_BEEF};
        vecs[4]  = '{1'b1, 32'h0000_1000, 32'h5555_5555, 1'b1, 32'hDEAD_BEEF};
        vecs[5]  = '{1'b0, 32'h0000_0000, 32'h0,         1'b0, 32'h0123_4567};
        vecs[6]  = '{1'b0, 32'h0000_1000, 32'h0,         1'b1, 32'h0000_0000};
        vecs[7]  = '{1'b0, 32'h0000_0024, 32'h0,         1'b0, 32'hCAFE_F00D};
        vecs[8]  = '{1'b1, 32'h0000_0030, 32'h0BAD_C0DE, 1'b0, 32'hCAFE_F00D};
        vecs[9]  = '{1'b0, 32'h8000_0010, 32'h0,         1'b1, 32'h0000_0000};
        vecs[10] = '{1'b0, 32'h0000_0010, 32'h0,         1'b0, 32'hDEAD_BEEF};
        vecs[11] = '{1'b1, 32'h0000_0020, 32'h5A5A_5A5A, 1'b0, 32'hDEAD_BEEF};

        do_reset();

        // LATENCY=1 instance: ready in the second cycle after the request cycle.
        l1_req = 1'b1; l1_write_en = 1'b1; l1_addr = 32'h40; l1_data_in = 32'h0102_0304;
        @(posedge clk); #1;
        chk("l1 wr busy", 32'(l1_busy), 32'd1);
        chk("l1 wr early ready", 32'(l1_ready), 32'd0);
        l1_req = 1'b0;
        @(posedge clk); #1;
        chk("l1 wr ready", 32'(l1_ready), 32'd1);
        chk("l1 wr busy off", 32'(l1_busy), 32'd0);
        l1_req = 1'b1; l1_write_en = 1'b0; l1_addr = 32'h40;
        @(posedge clk); #1;
        chk("l1 rd early ready", 32'(l1_ready), 32'd0);
        l1_req = 1'b0;
        @(posedge clk); #1;
        chk("l1 rd ready", 32'(l1_ready), 32'd1);
        chk("l1 rd err", 32'(l1_err), 32'd0);
        chk("l1 rd dout", l1_data_out, 32'h0102_0304);
        @(posedge clk); #1;
        chk("l1 ready pulse", 32'(l1_ready), 32'd0);

        for (int i = 0; i < 12; i++) begin
            run_req(vecs[i].we, vecs[i].addr, vecs[i].data, vecs[i].exp_err, vecs[i].exp_dout,
                    1'b0, 32'd0, 32'd0, $sformatf("vec%0d", i));
        end

        run_req(1'b0, 32'h20, 32'd0, 1'b0, 32'h5A5A_5A5A, 1'b1, 32'h24, 32'h1122_3344, "busy ignore");
        @(posedge clk); #1;
        chk("single ready", 32'(mem_ready), 32'd0);
        run_req(1'b0, 32'h24, 32'd0, 1'b0, 32'hCAFE_F00D, 1'b0, 32'd0, 32'd0, "ignored write");

        mem_req = 1'b1; mem_write_en = 1'b1; mem_addr = 32'h30; mem_data_in = 32'hAABB_CCDD;
        @(posedge clk); #1;
        mem_req = 1'b0;
        @(posedge clk); #1;
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        model_dout = 32'd0;
        chk("abort busy", 32'(mem_busy), 32'd0);
        for (int k = 0; k < LAT + 2; k++) begin
            @(posedge clk); #1;
            chk("abort no ready", 32'(mem_ready), 32'd0);
        end
        run_req(1'b0, 32'h30, 32'd0, 1'b0, 32'h0BAD_C0DE, 1'b0, 32'd0, 32'd0, "abort old value");
        run_req(1'b0, 32'h10, 32'd0, 1'b0, 32'hDEAD_BEEF, 1'b0, 32'd0, 32'd0, "survives reset");

        do_reset();
        for (int i = 0; i < 32; i++) begin
            data = $urandom;
            run_req(1'b1, 32'(i * 4), data, 1'b0, model_dout, 1'b0, 32'd0, 32'd0, "prefill");
            model_mem[i] = data;
        end
        for (int t = 0; t < 60; t++) begin
            idx  = $urandom_range(0, 31);
            addr = 32'(idx * 4) + 32'($urandom_range(0, 3));
            if ($urandom_range(0, 9) == 0) addr = addr | (32'd1 << $urandom_range(12, 31));
            oor  = addr >= 32'(4 * (1 << ADDR_W));
            we   = 1'($urandom_range(0, 1));
            data = $urandom;
            if (we) begin
                exp_dout = model_dout;
                if (!oor) model_mem[idx] = data;
            end else begin
                exp_dout   = oor ? 32'd0 : model_mem[idx];
                model_dout = exp_dout;
            end
            run_req(we, addr, data, oor, exp_dout, 1'($urandom_range(0, 1)),
                    $urandom, $urandom, $sformatf("rand%0d", t));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
